tx_fsm: RTL and testbench



---
 rtl/tx_pkg.sv | 22 ++
 rtl/tx_bit_cnt.sv | 30 +++
 rtl/tx_fsm.sv | 95 +++++++++
 tb/tb_tx_fsm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the UART transmitter control path.
package tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  // Counter width for a data field of n bits; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_bit_cnt.sv
// Data-bit counter for tx_fsm: runs while enabled, clears otherwise, flags the last bit.
module tx_bit_cnt
  import tx_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_en,
  output logic cnt_last
);

  localparam int CNT_W = cnt_width(data_width);

  logic [CNT_W-1:0] cnt_p0;

  // Holding at zero outside DATA means entry into DATA always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (cnt_en) begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end else begin
      cnt_p0 <= '0;
    end
  end

  assign cnt_last = (cnt_p0 == CNT_W'(data_width - 1));

endmodule

// File: rtl/tx_fsm.sv
// UART transmit frame sequencer (start, data, optional parity, stop), Moore outputs.
// Define TX_FSM_INT_BIT_CNT_EN to end DATA on an internal bit count as well as ser_done.
module tx_fsm
  import tx_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       ser_done,
  input  logic       par_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       ser_en
);

  tx_state_t state_p0;
  tx_state_t state_nxt;
  logic      data_exit;

  if (data_width < 1) begin : g_bad_width
    $error("tx_fsm: data_width must be at least 1");
  end

`ifdef TX_FSM_INT_BIT_CNT_EN
  logic cnt_last;

  tx_bit_cnt #(
    .data_width(data_width)
  ) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (state_p0 == ST_DATA),
    .cnt_last(cnt_last)
  );

  assign data_exit = ser_done | cnt_last;
`else
  assign data_exit = ser_done;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      ST_IDLE:   if (data_valid) state_nxt = ST_START;
      ST_START:  state_nxt = ST_DATA;
      ST_DATA:   if (data_exit) state_nxt = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP:   state_nxt = data_valid ? ST_START : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode the state register alone; unused encodings look idle.
  always_comb begin
    mux_sel = MUX_STOP;
    busy    = 1'b0;
    ser_en  = 1'b0;
    unique case (state_p0)
      ST_IDLE: begin
        mux_sel = MUX_STOP;
      end
      ST_START: begin
        mux_sel = MUX_START;
        busy    = 1'b1;
      end
      ST_DATA: begin
        mux_sel = MUX_DATA;
        busy    = 1'b1;
        ser_en  = 1'b1;
      end
      ST_PARITY: begin
        mux_sel = MUX_PAR;
        busy    = 1'b1;
      end
      ST_STOP: begin
        mux_sel = MUX_STOP;
        busy    = 1'b1;
      end
      default: begin
        mux_sel = MUX_STOP;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_fsm.sv
// Bench for tx_fsm: frames are planned at frame level, expanded into per-cycle expectations.
module tb_tx_fsm;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_valid;
  logic       ser_done;
  logic       par_en;
  logic [1:0] mux_sel;
  logic       busy;
  logic       ser_en;

  tx_fsm #(.data_width(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_valid(data_valid),
    .ser_done  (ser_done),
    .par_en    (par_en),
    .mux_sel   (mux_sel),
    .busy      (busy),
    .ser_en    (ser_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic       sd;
    logic       pe;
    logic [1:0] mux;
    logic       bsy;
    logic       en;
  } step_t;

  step_t plan[$];
  int    total = 0;
  int    bad = 0;
  int    seen_busy, seen_en, seen_idle, seen_b2b;
  bit    hold_dv = 1'b0;

  localparam logic [3:0] IDLE_OUT = 4'b0100;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: mux/busy/en got %b required %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic push(input logic dv, input logic sd, input logic pe,
                      input logic [1:0] mux, input logic b, input logic e);
    step_t s;
    s.dv  = hold_dv ? 1'b1 : dv;
    s.sd  = sd;
    s.pe  = pe;
    s.mux = mux;
    s.bsy = b;
    s.en  = e;
    plan.push_back(s);
  endtask

  // One frame: g idle cycles, start, len data cycles, optional parity, stop.
  task automatic add_frame(input int g, input int len, input bit p);
    int l;
    l = len;
`ifdef TX_FSM_INT_BIT_CNT_EN
    if (l > DW) l = DW;
`endif
    for (int i = 0; i < g; i++) push(1'b0, rb(), rb(), 2'b01, 1'b0, 1'b0);
    push(1'b1, rb(), rb(), 2'b00, 1'b1, 1'b0);
    push(rb(), rb(), rb(), 2'b10, 1'b1, 1'b1);
    for (int k = 1; k < l; k++) push(rb(), 1'b0, rb(), 2'b10, 1'b1, 1'b1);
    push(rb(), 1'b1, p, p ? 2'b11 : 2'b01, 1'b1, 1'b0);
    if (p) push(rb(), rb(), rb(), 2'b01, 1'b1, 1'b0);
  endtask

  task automatic add_idle();
    push(1'b0, rb(), rb(), 2'b01, 1'b0, 1'b0);
  endtask

  // Apply planned steps one per clock and compare after each edge; n<0 runs all.
  task automatic run_plan(input int n);
    step_t s;
    int    done;
    logic [1:0] prev_mux;
    logic       prev_busy;
    seen_busy = 0; seen_en = 0; seen_idle = 0; seen_b2b = 0;
    done = 0;
    prev_mux = mux_sel;
    prev_busy = busy;
    while (plan.size() > 0 && (n < 0 || done < n)) begin
      s = plan.pop_front();
      data_valid = s.dv;
      ser_done   = s.sd;
      par_en     = s.pe;
      @(posedge clk);
      #1;
      check("step", {mux_sel, busy, ser_en}, {s.mux, s.bsy, s.en});
      if (busy) seen_busy++; else seen_idle++;
      if (ser_en) seen_en++;
      if (prev_busy && busy && prev_mux == 2'b01 && mux_sel == 2'b00) seen_b2b++;
      prev_mux = mux_sel;
      prev_busy = busy;
      done++;
    end
  endtask

  initial begin
    rst = 1'b1;
    data_valid = 1'b1;
    ser_done = 1'b1;
    par_en = 1'b1;
    #1;
    check("reset_async", {mux_sel, busy, ser_en}, IDLE_OUT);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      data_valid = rb(); ser_done = rb(); par_en = rb();
      check("reset_hold", {mux_sel, busy, ser_en}, IDLE_OUT);
    end
    rst = 1'b0;
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) add_idle();
    run_plan(-1);

    // Frame without parity, ser_done on the 8th data cycle.
    add_frame(0, 8, 1'b0);
    check_int("model_np_len", plan.size(), 10);
    check_int("model_np_first", int'(plan[0].mux), 0);
    check_int("model_np_last", int'(plan[9].mux), 1);
    add_idle();
    run_plan(-1);
    check_int("np_en_cycles", seen_en, 8);
    check_int("np_busy_cycles", seen_busy, 10);

    // Frame with parity.
    add_frame(0, 8, 1'b1);
    check_int("model_par_len", plan.size(), 11);
    check_int("model_par_bit", int'(plan[9].mux), 3);
    add_idle();
    run_plan(-1);
    check_int("par_busy_cycles", seen_busy, 11);
    check_int("par_en_cycles", seen_en, 8);

    // Back-to-back frames with data_valid held high.
    hold_dv = 1'b1;
    add_frame(0, 8, 1'b0);
    add_frame(0, 3, 1'b1);
    add_frame(0, 5, 1'b0);
    hold_dv = 1'b0;
    run_plan(-1);
    check_int("b2b_idle_cycles", seen_idle, 0);
    check_int("b2b_stop_to_start", seen_b2b, 2);
    add_idle();
    add_idle();
    run_plan(-1);

    // ser_done on the very first data cycle.
    add_frame(0, 1, 1'b0);
    add_idle();
    run_plan(-1);
    check_int("early_en_cycles", seen_en, 1);
    check_int("early_busy_cycles", seen_busy, 3);

    // Reset asserted in the middle of DATA must act without a clock edge.
    add_frame(0, 8, 1'b0);
    run_plan(4);
    check_int("mid_in_data", int'(ser_en), 1);
    plan.delete();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_async", {mux_sel, busy, ser_en}, IDLE_OUT);
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_valid = 1'b0;
    check("mid_rst_hold", {mux_sel, busy, ser_en}, IDLE_OUT);
    add_idle();
    run_plan(-1);

    // Randomized frames with random gaps, lengths, parity and ignored-input noise.
    for (int f = 0; f < 40; f++) begin
      add_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), rb());
    end
    add_idle();
    run_plan(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
